buffer_read_sequencer: RTL and testbench

- Controller that sequences reads out of the 4-entry, 8-bit buffer block.
- On a start command it drives the buffer read address through a burst of 1-4 consecutive entries from a given start address, wrapping 3->0.
- It registers each buffer output byte into a valid/ready output stage and pulses done when the burst completes.
- It asserts buffer_hold while busy so upstream keeps the buffer inputs stable.

---
 rtl/buffer_read_sequencer_pkg.sv | 13 +
 rtl/buffer_read_sequencer_out_stage.sv | 41 ++++
 rtl/buffer_read_sequencer.sv | 110 +++++++++++
 tb/tb_buffer_read_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/buffer_read_sequencer_pkg.sv
// Shared constants for the buffer read sequencer: default geometry and the
// encoding of the three sequencer states.
package buffer_read_sequencer_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 2;
   localparam int DEF_DEPTH      = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/buffer_read_sequencer_out_stage.sv
// Single-entry valid/ready output register. A new byte may be loaded whenever
// the register is empty or its current byte is being taken this cycle, so the
// held byte never changes while it is offered and not yet accepted.
module seq_out_stage
   import buffer_read_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_clear,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_can_load
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   // Room for a new byte: empty, or the current byte leaves this cycle.
   assign o_can_load = !r_valid || i_ready;
   assign o_data     = r_data;
   assign o_valid    = r_valid;

   // Capture a byte on load; drop valid when the last byte is consumed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/buffer_read_sequencer.sv
// Sequences a burst of 1..DEPTH consecutive reads from the small buffer,
// wrapping the address naturally, and streams each byte through a
// valid/ready output register. done pulses once after the last byte is taken.
module buffer_read_sequencer
   import buffer_read_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   burst_len,
   output logic [ADDR_WIDTH-1:0] buffer_read_addr_out,
   input  logic [DATA_WIDTH-1:0] buffer_data_in,
   output logic                  buffer_hold,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_remaining;
   logic                  r_done;

   logic [ADDR_WIDTH:0]   w_len;
   logic                  w_can_load;
   logic                  w_adv;
   logic                  w_drain_hs;

   // Requests longer than the buffer read every entry exactly once.
   assign w_len = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;

   // A beat advances only in RUN and only when the output register has room.
   assign w_adv      = (r_state == ST_RUN) && w_can_load;
   // Final byte accepted by the consumer while draining.
   assign w_drain_hs = (r_state == ST_DRAIN) && out_valid && out_ready;

   assign busy                 = (r_state != ST_IDLE);
   assign buffer_hold          = (r_state != ST_IDLE);
   assign buffer_read_addr_out = r_addr;
   assign done                 = r_done;

   seq_out_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_stage (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_adv),
      .i_clear    (w_drain_hs),
      .i_data     (buffer_data_in),
      .i_ready    (out_ready),
      .o_data     (out_data),
      .o_valid    (out_valid),
      .o_can_load (w_can_load)
   );

   // Burst control: accept start in IDLE, step address per beat, pulse done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (w_len == '0) begin
                     // Empty burst: nothing to read, just acknowledge.
                     r_done <= 1'b1;
                  end else begin
                     r_addr      <= start_addr;
                     r_remaining <= w_len;
                     r_state     <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_adv) begin
                  r_addr      <= r_addr + 1'b1;
                  r_remaining <= r_remaining - LEN_ONE;
                  if (r_remaining == LEN_ONE) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_drain_hs) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buffer_read_sequencer.sv
// Directed bench for buffer_read_sequencer: a behavioural 4-entry buffer
// feeds the DUT and each step checks outputs 1 ns after the rising edge.
module tb_buffer_read_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] start_addr;
   logic [2:0] burst_len;
   logic [1:0] buffer_read_addr_out;
   logic [7:0] buffer_data_in;
   logic       buffer_hold;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;

   logic [7:0] mem [4];
   int total;
   int bad;

   buffer_read_sequencer dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .start_addr           (start_addr),
      .burst_len            (burst_len),
      .buffer_read_addr_out (buffer_read_addr_out),
      .buffer_data_in       (buffer_data_in),
      .buffer_hold          (buffer_hold),
      .out_data             (out_data),
      .out_valid            (out_valid),
      .out_ready            (out_ready),
      .busy                 (busy),
      .done                 (done)
   );

   assign buffer_data_in = mem[buffer_read_addr_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic exp_done);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_hold"}, buffer_hold, 1'b0);
      chk1({tag, "_valid"}, out_valid, 1'b0);
      chk1({tag, "_done"}, done, exp_done);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mem[0] = 8'hA0; mem[1] = 8'hB1; mem[2] = 8'hC2; mem[3] = 8'hD3;
      rst = 1'b0; start = 1'b0; start_addr = 2'd0; burst_len = 3'd0; out_ready = 1'b0;

      // Reset held for two cycles, then released
      tick(); tick();
      chk_idle("rst", 1'b0);
      chk8("rst_addr", 8'(buffer_read_addr_out), 8'h00);
      chk8("rst_data", out_data, 8'h00);
      rst = 1'b1;
      tick();
      chk_idle("post_rst", 1'b0);
      $display("txn reset: busy=%b valid=%b addr=%0d", busy, out_valid, buffer_read_addr_out);

      // Basic burst of 4 from address 0 with ready held high
      out_ready = 1'b1; start = 1'b1; start_addr = 2'd0; burst_len = 3'd4;
      tick();
      start = 1'b0;
      chk1("basic_busy", busy, 1'b1);
      chk1("basic_hold", buffer_hold, 1'b1);
      chk1("basic_valid0", out_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("basic_valid", out_valid, 1'b1);
         chk8("basic_data", out_data, mem[2'(i)]);
         chk8("basic_addr", 8'(buffer_read_addr_out), 8'((i + 1) % 4));
         chk1("basic_nodone", done, 1'b0);
         $display("txn basic beat %0d: data=%02h", i, out_data);
      end
      tick();
      chk_idle("basic_end", 1'b1);
      tick();
      chk1("basic_done_once", done, 1'b0);

      // Wrap-around: 3 beats from address 3 -> D3, A0, B1
      start = 1'b1; start_addr = 2'd3; burst_len = 3'd3;
      tick();
      start = 1'b0;
      chk8("wrap_addr0", 8'(buffer_read_addr_out), 8'h03);
      tick(); chk8("wrap_d0", out_data, 8'hD3);
      tick(); chk8("wrap_d1", out_data, 8'hA0);
      tick(); chk8("wrap_d2", out_data, 8'hB1);
      chk1("wrap_nodone", done, 1'b0);
      tick();
      chk_idle("wrap_end", 1'b1);
      $display("txn wrap: done=%b", done);

      // Backpressure: 2 beats, consumer stalls 3 cycles after the first valid
      out_ready = 1'b0; start = 1'b1; start_addr = 2'd0; burst_len = 3'd2;
      tick();
      start = 1'b0;
      tick();
      chk1("bp_valid", out_valid, 1'b1);
      chk8("bp_d0", out_data, 8'hA0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk8("bp_hold_data", out_data, 8'hA0);
         chk1("bp_hold_valid", out_valid, 1'b1);
         chk8("bp_hold_addr", 8'(buffer_read_addr_out), 8'h01);
         chk1("bp_hold_busy", busy, 1'b1);
      end
      out_ready = 1'b1;
      tick();
      chk8("bp_d1", out_data, 8'hB1);
      chk1("bp_nodone", done, 1'b0);
      tick();
      chk_idle("bp_end", 1'b1);
      $display("txn backpressure: done=%b", done);

      // Zero-length start: no data, done next cycle
      start = 1'b1; burst_len = 3'd0;
      tick();
      start = 1'b0;
      chk_idle("zero", 1'b1);
      tick();
      chk_idle("zero_after", 1'b0);
      $display("txn zero-length");

      // Start while busy must be ignored
      start = 1'b1; start_addr = 2'd0; burst_len = 3'd2;
      tick();
      start_addr = 2'd3; burst_len = 3'd4;
      tick();
      chk8("ign_d0", out_data, 8'hA0);
      chk8("ign_addr", 8'(buffer_read_addr_out), 8'h01);
      tick();
      chk8("ign_d1", out_data, 8'hB1);
      start = 1'b0;
      tick();
      chk_idle("ign_end", 1'b1);
      $display("txn start-while-busy ignored");

      // Start in the done cycle is accepted: 1 beat from address 2
      start = 1'b1; start_addr = 2'd2; burst_len = 3'd1;
      tick();
      start = 1'b0;
      chk1("dc_busy", busy, 1'b1);
      chk1("dc_done_low", done, 1'b0);
      chk8("dc_addr", 8'(buffer_read_addr_out), 8'h02);
      tick();
      chk8("dc_d0", out_data, 8'hC2);
      tick();
      chk_idle("dc_end", 1'b1);
      $display("txn start-in-done-cycle");

      // Oversized length (7) behaves as 4: B1, C2, D3, A0
      start = 1'b1; start_addr = 2'd1; burst_len = 3'd7;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk8("clamp_data", out_data, mem[2'((i + 1) % 4)]);
      end
      tick();
      chk_idle("clamp_end", 1'b1);
      $display("txn oversize length");

      // Reset mid-burst after two beats: no done pulse
      start = 1'b1; start_addr = 2'd0; burst_len = 3'd4;
      tick();
      start = 1'b0;
      tick(); tick();
      chk8("mid_d1", out_data, 8'hB1);
      rst = 1'b0;
      tick();
      chk_idle("mid_rst", 1'b0);
      chk8("mid_rst_addr", 8'(buffer_read_addr_out), 8'h00);
      chk8("mid_rst_data", out_data, 8'h00);
      rst = 1'b1;
      tick();
      chk_idle("mid_after", 1'b0);
      tick();
      chk1("mid_nodone", done, 1'b0);
      $display("txn reset mid-burst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
